elevator_scheduler: RTL and testbench
=====================================

# elevator_scheduler

Four-floor elevator request scheduler: latches hall and cab calls, tracks car position from the floor sensors, and sequences the motor and door with a SCAN (keep-direction) policy. It sits between the button/sensor pins and the motor/door drivers, replacing ad-hoc per-button latching with one registered request table and one state machine.

## Interface

- DOOR_CYCLES, 8, clock cycles the door stays open per stop (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- S1, S2, S3, S4  input  1 each  floor sensors, high while car is level at that floor
- U1, U2, U3  input  1 each  hall up-call buttons (no U4)
- D2, D3, D4  input  1 each  hall down-call buttons (no D1)
- F1, F2, F3, F4  input  1 each  in-car floor buttons
- door_hold  input  1  extend door-open time (present only with ELEVATOR_DOOR_HOLD_EN)
- up, down, stop  output  1 each  motor command, exactly one high
- open_door  output  1  door open command
- monitor  output  2  current floor, 0 = floor 1 … 3 = floor 4
- pending  output  12  request table {cab[3:0], dn[3:0], up[3:0]}; up[3] and dn[0] always 0

## Operation

- Request table: up_req, dn_req, cab_req, 4 bits each. Each bit is set on any clock edge where its button is high and held until served. Buttons are level-sampled; holding a button is the same as one press.
- Floor tracking: cur_floor updates only on an edge where exactly one S input is high; zero or multiple high sensors hold cur_floor. monitor = cur_floor.
- at_floor = sensor for cur_floor high. req_at(f) = up_req[f] | dn_req[f] | cab_req[f]. above/below = any request on floors strictly above/below cur_floor.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN. Outputs are decoded from the state register only: IDLE/DOOR_OPEN → stop=1; MOVE_UP → up=1; MOVE_DOWN → down=1; DOOR_OPEN → open_door=1.
- IDLE: if at_floor and req_at(cur_floor) → DOOR_OPEN; else if above → MOVE_UP; else if below → MOVE_DOWN; else stay. Ties go to the last travel direction (reset value: up).
- MOVE_UP, on an edge where a new floor f's sensor is high: if cab_req[f] | up_req[f] | (dn_req[f] & no request above f) → DOOR_OPEN; else if f = 3 → IDLE; else continue. MOVE_DOWN mirrors this: cab/dn at f, up only if nothing below f, forced stop at f = 0.
- Entering DOOR_OPEN at floor f clears cab_req[f], up_req[f] and dn_req[f] in the same edge. While in DOOR_OPEN, presses for floor f are ignored; presses for other floors are latched.
- DOOR_OPEN: down-counter loaded with DOOR_CYCLES−1 on entry, decrements each cycle; at 0 → IDLE.
- Reset: state IDLE, direction up, cur_floor 0, all requests 0, counter 0; outputs stop=1, up=0, down=0, open_door=0, monitor=0, pending=0.

## Timing

- Button high at edge k → pending bit visible after edge k.
- Car idle at a different floor, request latched at edge k → IDLE decides at edge k+1 → up/down high after edge k+1.
- Sensor for target floor high at edge m → open_door high and motor stop after edge m (one cycle of motor output after the sensor rises).
- Door open for exactly DOOR_CYCLES cycles, then stop only (IDLE) for at least one cycle before the motor restarts.
- Request for the current floor while IDLE and at_floor → door opens one cycle after latch, no motion.
- Reset mid-motion drops the motor command on the next edge; cur_floor returns to 0 until a sensor is seen.

## Configuration

- ELEVATOR_DOOR_HOLD_EN defined: door_hold port exists. Each DOOR_OPEN cycle with door_hold high reloads the counter to DOOR_CYCLES−1, so the door closes DOOR_CYCLES cycles after the last hold.
- ELEVATOR_DOOR_HOLD_EN undefined: no door_hold port. The door time is fixed at DOOR_CYCLES.

## Test plan

- Reset, then S1 high and idle for 5 cycles → stop=1, up=down=open_door=0, monitor=0, pending=0.
- At floor 1, pulse F3 → pending[10]=1, up high 2 cycles after the press; assert S3 → open_door=1 for 8 cycles, pending=0, monitor=2, then stop.
- Moving up from floor 1 with D2 and F4 pending; S2 passes → no stop at floor 2; stops at floor 4; then reverses down and serves D2.
- Car at floor 2, press U2 and F2 in the same cycle → door opens the next cycle with no motion, both bits cleared; pressing F2 during DOOR_OPEN is ignored.
- S2 and S3 high together → monitor holds its previous value.
- With ELEVATOR_DOOR_HOLD_EN: hold door_hold for 20 cycles during DOOR_OPEN → door closes 8 cycles after hold drops. Without the macro: the door closes after 8 cycles.

Source files
------------

// File: rtl/elevator_scheduler.sv
// Four-floor SCAN elevator scheduler: registered request table, floor tracking, motor/door FSM.
// Optional door-hold input is enabled by defining ELEVATOR_DOOR_HOLD_EN.
module elevator_scheduler #(
    parameter int DOOR_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       S1,
    input  logic       S2,
    input  logic       S3,
    input  logic       S4,
    input  logic       U1,
    input  logic       U2,
    input  logic       U3,
    input  logic       D2,
    input  logic       D3,
    input  logic       D4,
    input  logic       F1,
    input  logic       F2,
    input  logic       F3,
    input  logic       F4,
`ifdef ELEVATOR_DOOR_HOLD_EN
    input  logic       door_hold,
`endif
    output logic       up,
    output logic       down,
    output logic       stop,
    output logic       open_door,
    output logic [1:0] monitor,
    output logic [11:0] pending
);

    localparam int CNT_W = $clog2(DOOR_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN
    } state_t;

    state_t           state, state_nxt;
    logic             dir_up, dir_up_nxt;
    logic [1:0]       cur_floor, cur_floor_nxt;
    logic [3:0]       up_req, dn_req, cab_req;
    logic [3:0]       up_req_nxt, dn_req_nxt, cab_req_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [3:0] sens, up_btn, dn_btn, cab_btn;
    logic [3:0] req_any, clr_mask;
    logic [1:0] sens_floor, open_floor;
    logic       sens_valid, new_floor, open_en, hold;
    logic       above, below, stop_up, stop_dn;

    assign sens    = {S4, S3, S2, S1};
    assign up_btn  = {1'b0, U3, U2, U1};
    assign dn_btn  = {D4, D3, D2, 1'b0};
    assign cab_btn = {F4, F3, F2, F1};
    assign req_any = up_req | dn_req | cab_req;

`ifdef ELEVATOR_DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif

    function automatic logic any_above(input logic [3:0] req, input logic [1:0] f);
        any_above = |(req & (4'b1110 << f));
    endfunction

    function automatic logic any_below(input logic [3:0] req, input logic [1:0] f);
        any_below = |(req & ~(4'b1111 << f));
    endfunction

    // Only a single active sensor identifies a floor; anything else is ambiguous.
    always_comb begin
        sens_valid = 1'b1;
        sens_floor = cur_floor;
        case (sens)
            4'b0001: sens_floor = 2'd0;
            4'b0010: sens_floor = 2'd1;
            4'b0100: sens_floor = 2'd2;
            4'b1000: sens_floor = 2'd3;
            default: sens_valid = 1'b0;
        endcase
    end

    assign cur_floor_nxt = sens_valid ? sens_floor : cur_floor;
    assign new_floor     = sens_valid && (sens_floor != cur_floor);
    assign above         = any_above(req_any, cur_floor);
    assign below         = any_below(req_any, cur_floor);

    // Opposite-direction calls are only worth a stop when nothing lies further ahead.
    assign stop_up = cab_req[sens_floor] | up_req[sens_floor]
                   | (dn_req[sens_floor] & ~any_above(req_any, sens_floor));
    assign stop_dn = cab_req[sens_floor] | dn_req[sens_floor]
                   | (up_req[sens_floor] & ~any_below(req_any, sens_floor));

    always_comb begin
        state_nxt  = state;
        dir_up_nxt = dir_up;
        cnt_nxt    = cnt;
        open_en    = 1'b0;
        open_floor = cur_floor;
        unique case (state)
            IDLE: begin
                if (sens[cur_floor] && req_any[cur_floor]) begin
                    state_nxt = DOOR_OPEN;
                    open_en   = 1'b1;
                    cnt_nxt   = CNT_LOAD;
                end else if (above && (dir_up || !below)) begin
                    state_nxt  = MOVE_UP;
                    dir_up_nxt = 1'b1;
                end else if (below) begin
                    state_nxt  = MOVE_DOWN;
                    dir_up_nxt = 1'b0;
                end
            end
            MOVE_UP: begin
                if (new_floor) begin
                    if (stop_up) begin
                        state_nxt  = DOOR_OPEN;
                        open_en    = 1'b1;
                        open_floor = sens_floor;
                        cnt_nxt    = CNT_LOAD;
                    end else if (sens_floor == 2'd3) begin
                        state_nxt = IDLE;
                    end
                end
            end
            MOVE_DOWN: begin
                if (new_floor) begin
                    if (stop_dn) begin
                        state_nxt  = DOOR_OPEN;
                        open_en    = 1'b1;
                        open_floor = sens_floor;
                        cnt_nxt    = CNT_LOAD;
                    end else if (sens_floor == 2'd0) begin
                        state_nxt = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                if (hold) begin
                    cnt_nxt = CNT_LOAD;
                end else if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
        endcase
    end

    // Calls for the floor being served are dropped on entry and for the whole door time.
    always_comb begin
        clr_mask = 4'b0000;
        if (open_en) begin
            clr_mask[open_floor] = 1'b1;
        end
        if (state == DOOR_OPEN) begin
            clr_mask[cur_floor] = 1'b1;
        end
    end

    assign up_req_nxt  = (up_req  | up_btn)  & ~clr_mask;
    assign dn_req_nxt  = (dn_req  | dn_btn)  & ~clr_mask;
    assign cab_req_nxt = (cab_req | cab_btn) & ~clr_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dir_up    <= 1'b1;
            cur_floor <= 2'd0;
            up_req    <= 4'b0000;
            dn_req    <= 4'b0000;
            cab_req   <= 4'b0000;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            dir_up    <= dir_up_nxt;
            cur_floor <= cur_floor_nxt;
            up_req    <= up_req_nxt;
            dn_req    <= dn_req_nxt;
            cab_req   <= cab_req_nxt;
            cnt       <= cnt_nxt;
        end
    end

    assign up        = (state == MOVE_UP);
    assign down      = (state == MOVE_DOWN);
    assign stop      = (state == IDLE) || (state == DOOR_OPEN);
    assign open_door = (state == DOOR_OPEN);
    assign monitor   = cur_floor;
    assign pending   = {cab_req, dn_req, up_req};

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus random calls, checked every cycle
// against a floor-by-floor behavioural model driving a simple car-position model.
module tb_elevator_scheduler;

    localparam int DC     = 8;
    localparam int IDLE_M = 0;
    localparam int UP_M   = 1;
    localparam int DN_M   = 2;
    localparam int DOOR_M = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  sens, bu, bd, cab;
`ifdef ELEVATOR_DOOR_HOLD_EN
    logic        door_hold;
`endif
    logic        up, down, stop, open_door;
    logic [1:0]  monitor;
    logic [11:0] pending;

    int   n_pass = 0;
    int   n_checks = 0;
    int   pos = 0;
    bit   ovr_en = 0;
    logic [3:0] ovr = 4'b0000;

    int m_state, m_floor, m_cnt;
    bit m_dir_up;
    bit m_up[4], m_dn[4], m_cab[4];

    always #5 clk = ~clk;

    elevator_scheduler #(.DOOR_CYCLES(DC)) dut (
        .clk(clk), .reset(reset),
        .S1(sens[0]), .S2(sens[1]), .S3(sens[2]), .S4(sens[3]),
        .U1(bu[0]), .U2(bu[1]), .U3(bu[2]),
        .D2(bd[1]), .D3(bd[2]), .D4(bd[3]),
        .F1(cab[0]), .F2(cab[1]), .F3(cab[2]), .F4(cab[3]),
`ifdef ELEVATOR_DOOR_HOLD_EN
        .door_hold(door_hold),
`endif
        .up(up), .down(down), .stop(stop), .open_door(open_door),
        .monitor(monitor), .pending(pending)
    );

    function automatic bit m_req(input int f);
        return m_up[f] || m_dn[f] || m_cab[f];
    endfunction

    function automatic bit m_above(input int f);
        for (int g = f + 1; g < 4; g++) if (m_req(g)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_below(input int f);
        for (int g = 0; g < f; g++) if (m_req(g)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        int n_s, sf, open_f, nxt;
        bit hold;
`ifdef ELEVATOR_DOOR_HOLD_EN
        hold = door_hold;
`else
        hold = 1'b0;
`endif
        if (reset) begin
            m_state = IDLE_M; m_dir_up = 1'b1; m_floor = 0; m_cnt = 0;
            for (int g = 0; g < 4; g++) begin m_up[g] = 0; m_dn[g] = 0; m_cab[g] = 0; end
            return;
        end
        n_s = 0; sf = 0;
        for (int i = 0; i < 4; i++) if (sens[i]) begin n_s++; sf = i; end
        open_f = -1;
        nxt = m_state;
        case (m_state)
            IDLE_M: begin
                if (sens[m_floor] && m_req(m_floor)) begin nxt = DOOR_M; open_f = m_floor; end
                else if (m_above(m_floor) && m_below(m_floor)) nxt = m_dir_up ? UP_M : DN_M;
                else if (m_above(m_floor)) nxt = UP_M;
                else if (m_below(m_floor)) nxt = DN_M;
            end
            UP_M: if (n_s == 1 && sf != m_floor) begin
                if (m_cab[sf] || m_up[sf] || (m_dn[sf] && !m_above(sf))) begin
                    nxt = DOOR_M; open_f = sf;
                end else if (sf == 3) nxt = IDLE_M;
            end
            DN_M: if (n_s == 1 && sf != m_floor) begin
                if (m_cab[sf] || m_dn[sf] || (m_up[sf] && !m_below(sf))) begin
                    nxt = DOOR_M; open_f = sf;
                end else if (sf == 0) nxt = IDLE_M;
            end
            default: begin
                if (hold) m_cnt = DC - 1;
                else if (m_cnt == 0) nxt = IDLE_M;
                else m_cnt--;
            end
        endcase
        if (open_f >= 0) m_cnt = DC - 1;
        if (nxt == UP_M) m_dir_up = 1'b1;
        if (nxt == DN_M) m_dir_up = 1'b0;
        for (int g = 0; g < 4; g++) begin
            bit clr;
            clr = (g == open_f) || (m_state == DOOR_M && g == m_floor);
            m_up[g]  = (m_up[g]  || (bu[g] && g != 3)) && !clr;
            m_dn[g]  = (m_dn[g]  || (bd[g] && g != 0)) && !clr;
            m_cab[g] = (m_cab[g] || cab[g]) && !clr;
        end
        if (n_s == 1) m_floor = sf;
        m_state = nxt;
    endtask

    function automatic logic [31:0] exp_vec();
        logic [11:0] p;
        for (int g = 0; g < 4; g++) begin
            p[g] = m_up[g]; p[4+g] = m_dn[g]; p[8+g] = m_cab[g];
        end
        return {14'd0, m_state == UP_M, m_state == DN_M,
                (m_state == IDLE_M || m_state == DOOR_M), m_state == DOOR_M, 2'(m_floor), p};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic update_sens();
        if (ovr_en) sens = ovr;
        else for (int i = 0; i < 4; i++) sens[i] = (pos == 4 * i);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("cycle", {14'd0, up, down, stop, open_door, monitor, pending}, exp_vec());
        if (m_state == UP_M && pos < 12) pos++;
        else if (m_state == DN_M && pos > 0) pos--;
        update_sens();
    endtask

    task automatic wait_open(input string tag);
        int n;
        n = 0;
        while (open_door !== 1'b1 && n < 100) begin tick(); n++; end
        chk(tag, {31'd0, open_door}, 32'd1);
    endtask

    task automatic wait_close(output int n);
        n = 0;
        while (open_door === 1'b1 && n < 100) begin tick(); n++; end
    endtask

    task automatic press(input logic [3:0] u, input logic [3:0] d, input logic [3:0] c);
        bu = u; bd = d; cab = c;
        tick();
        bu = 4'b0000; bd = 4'b0000; cab = 4'b0000;
    endtask

    initial begin
        int n;
        reset = 1'b1; bu = 4'b0000; bd = 4'b0000; cab = 4'b0000;
`ifdef ELEVATOR_DOOR_HOLD_EN
        door_hold = 1'b0;
`endif
        pos = 0;
        update_sens();
        tick(); tick();
        reset = 1'b0;

        // Reset state, idle at floor 1
        repeat (5) tick();
        chk("rst_stop", {31'd0, stop}, 32'd1);
        chk("rst_motor", {29'd0, up, down, open_door}, 32'd0);
        chk("rst_monitor", {30'd0, monitor}, 32'd0);
        chk("rst_pending", {20'd0, pending}, 32'd0);

        // Cab call to floor 3
        press(4'b0000, 4'b0000, 4'b0100);
        chk("f3_latch", {20'd0, pending}, 32'h400);
        tick();
        chk("f3_up", {31'd0, up}, 32'd1);
        wait_open("f3_open");
        chk("f3_monitor", {30'd0, monitor}, 32'd2);
        chk("f3_pending", {20'd0, pending}, 32'd0);
        wait_close(n);
        chk("f3_door_len", n, 32'd8);
        chk("f3_stop_after", {29'd0, stop, up, down}, 32'b100);

        // Back to floor 1, then D2 + F4: skip floor 2 going up, serve it coming down
        press(4'b0000, 4'b0000, 4'b0001);
        wait_open("f1_open");
        chk("f1_monitor", {30'd0, monitor}, 32'd0);
        wait_close(n);
        press(4'b0000, 4'b0010, 4'b1000);
        chk("scan_latch", {20'd0, pending}, 32'h820);
        wait_open("scan_open4");
        chk("scan_skip2", {30'd0, monitor}, 32'd3);
        wait_close(n);
        wait_open("scan_open2");
        chk("scan_reverse", {30'd0, monitor}, 32'd1);
        chk("scan_pending", {20'd0, pending}, 32'd0);
        wait_close(n);

        // Same-floor U2 + F2 while idle at floor 2
        press(4'b0010, 4'b0000, 4'b0010);
        chk("same_latch", {20'd0, pending}, 32'h202);
        tick();
        chk("same_open", {31'd0, open_door}, 32'd1);
        chk("same_clear", {20'd0, pending}, 32'd0);
        chk("same_nomotion", {30'd0, up, down}, 32'd0);
        press(4'b0000, 4'b0000, 4'b0010);
        chk("same_ignore", {20'd0, pending}, 32'd0);
        wait_close(n);

        // Two sensors at once hold the floor
        ovr = 4'b0110; ovr_en = 1'b1; update_sens();
        tick();
        chk("dual_sensor", {30'd0, monitor}, 32'd1);
        tick();
        chk("dual_sensor2", {30'd0, monitor}, 32'd1);
        ovr_en = 1'b0; update_sens();

        // Door time, with and without hold
        press(4'b0000, 4'b0000, 4'b0010);
        tick();
        chk("door_entry", {31'd0, open_door}, 32'd1);
`ifdef ELEVATOR_DOOR_HOLD_EN
        door_hold = 1'b1;
        repeat (20) tick();
        door_hold = 1'b0;
        chk("hold_open", {31'd0, open_door}, 32'd1);
        wait_close(n);
        chk("hold_len", n, 32'd8);
`else
        wait_close(n);
        chk("door_len", n, 32'd8);
`endif

        // Random calls, with one reset mid-run
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) begin
                reset = 1'b1; pos = 0; update_sens();
                tick();
                chk("rst_motion", {30'd0, up, down}, 32'd0);
                reset = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                bu[i]  = ($urandom_range(0, 39) == 0);
                bd[i]  = ($urandom_range(0, 39) == 0);
                cab[i] = ($urandom_range(0, 39) == 0);
            end
            bu[3] = 1'b0; bd[0] = 1'b0;
`ifdef ELEVATOR_DOOR_HOLD_EN
            door_hold = ($urandom_range(0, 7) == 0);
`endif
            tick();
        end
        bu = 4'b0000; bd = 4'b0000; cab = 4'b0000;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
